// File: rtl/mem_wb_skid.sv
// MEM/WB pipeline register with a two-entry skid buffer: head drives WB, skid absorbs
// one extra entry so in_ready can come from a flop instead of from out_ready.
module mem_wb_skid #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RA_W   = 6,
  parameter int unsigned PROD_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_memtoreg,
  input  logic              in_regwrite,
  input  logic [DATA_W-1:0] in_dm_out,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [RA_W-1:0]   in_rd,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic              out_memtoreg,
  output logic              out_regwrite,
  output logic [DATA_W-1:0] out_dm_out,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_wb_data,
  output logic [RA_W-1:0]   out_rd,
  output logic [PROD_W-1:0] out_prod,
  output logic [1:0]        occupancy
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  typedef struct packed {
    logic              memtoreg;
    logic              regwrite;
    logic [DATA_W-1:0] dm_out;
    logic [DATA_W-1:0] alu;
    logic [RA_W-1:0]   rd;
    logic [PROD_W-1:0] prod;
  } entry_t;

  logic [1:0] state_q, state_d;
  entry_t     head_q, head_d;
  entry_t     skid_q, skid_d;
  entry_t     in_entry;
  logic       in_ready_q;
  logic       push, pop;

  assign in_entry  = {in_memtoreg, in_regwrite, in_dm_out, in_alu, in_rd, in_prod};
  assign out_valid = (state_q == ONE) || (state_q == FULL);
  assign in_ready  = in_ready_q;
  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      // Kill entries but keep data fields; only validity and control bits go.
      state_d         = EMPTY;
      head_d.memtoreg = 1'b0;
      head_d.regwrite = 1'b0;
      skid_d.memtoreg = 1'b0;
      skid_d.regwrite = 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            head_d  = in_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b10: begin
              skid_d  = in_entry;
              state_d = FULL;
            end
            2'b01: state_d = EMPTY;
            2'b11: head_d = in_entry;
            default: ;
          endcase
        end
        FULL: begin
          if (pop) begin
            head_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  assign out_memtoreg = head_q.memtoreg & out_valid;
  assign out_regwrite = head_q.regwrite & out_valid;
  assign out_dm_out   = head_q.dm_out;
  assign out_alu      = head_q.alu;
  assign out_rd       = head_q.rd;
  assign out_prod     = head_q.prod;
  assign out_wb_data  = head_q.memtoreg ? head_q.dm_out : head_q.alu;
  assign occupancy    = state_q;

endmodule

// File: doc/mem_wb_skid.md
MEM_WB_SKID -- requirements
Module: mem_wb_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of memory-data and ALU-result fields.
REQ-002 SHALL have parameter RA_W, default 6: width of destination-register field.
REQ-003 SHALL have parameter PROD_W, default 64: width of multiplier-product field.
REQ-004 SHALL have port clock  in  1  single rising-edge clock; one clock only.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  in  1  MEM stage presents an entry.
REQ-007 SHALL have port in_ready  out  1  block accepts an entry this cycle.
REQ-008 SHALL have ports in_memtoreg, in_regwrite  in  1 each  control bits of the entry.
REQ-009 SHALL have ports in_dm_out, in_alu  in  DATA_W each  memory read data and ALU result.
REQ-010 SHALL have ports in_rd  in  RA_W and in_prod  in  PROD_W  destination register and product.
REQ-011 SHALL have port flush  in  1  synchronous kill of all held entries.
REQ-012 SHALL have port out_ready  in  1  WB stage consumes the head entry.
REQ-013 SHALL have ports out_valid, out_memtoreg, out_regwrite  out  1 each  head-entry status and control.
REQ-014 SHALL have ports out_dm_out, out_alu, out_wb_data  out  DATA_W each  head fields and selected write-back value.
REQ-015 SHALL have ports out_rd  out  RA_W, out_prod  out  PROD_W, occupancy  out  2  head fields and entry count.

Function
REQ-016 SHALL hold at most two entries: head (drives outputs) and skid; occupancy SHALL be 0, 1 or 2.
REQ-017 SHALL be a state machine: EMPTY (0 entries), ONE (1), FULL (2); occupancy SHALL equal the state encoding.
REQ-018 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready, sampled at the rising clock edge.
REQ-019 SHALL drive in_ready from a register: 1 in EMPTY and ONE, 0 in FULL; no combinational path from out_ready to in_ready.
REQ-020 SHALL drive out_valid = 1 exactly in ONE and FULL.
REQ-021 SHALL transition EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; ONE->ONE on push with pop (head replaced by the new entry); FULL->ONE on pop (skid moves to head); otherwise hold.
REQ-022 SHALL give one-cycle latency: an entry pushed at edge N SHALL appear on the outputs after edge N when the block was EMPTY or popped at edge N.
REQ-023 SHALL preserve order and never drop or duplicate entries when flush = 0.
REQ-024 SHALL drive out_wb_data = out_memtoreg ? out_dm_out : out_alu combinationally from the head registers.
REQ-025 SHALL force out_regwrite and out_memtoreg to 0 whenever out_valid = 0, regardless of stored values.
REQ-026 SHALL, on flush at an edge, go to EMPTY and set in_ready = 1; flush SHALL take priority over a simultaneous push (that entry discarded) and pop.
REQ-027 SHALL leave data fields unchanged on flush; only valid state and control bits are cleared.
REQ-028 SHALL ignore all in_* fields when push = 0 and keep the head stable while out_valid = 1 and out_ready = 0.

Reset
REQ-029 SHALL, while reset = 0, immediately enter EMPTY: out_valid = 0, in_ready = 1, occupancy = 0, control outputs 0, all data fields 0.
REQ-030 SHALL, on reset assertion mid-operation, discard both entries without waiting for a clock edge.
REQ-031 SHALL accept a push on the first rising edge after reset deasserts.

Verification
REQ-032 Basic pass: push rd=5, alu=0x1234, memtoreg=0, regwrite=1, out_ready=1 -> next cycle out_valid=1, out_wb_data=0x1234, out_rd=5, out_regwrite=1; following cycle out_valid=0.
REQ-033 Backpressure: out_ready=0, push A (dm_out=0xAAAA, memtoreg=1), B, C -> after B occupancy=2, in_ready=0, C not accepted; release out_ready -> A, B emerge in order, out_wb_data=0xAAAA first.
REQ-034 Simultaneous push/pop in ONE: head A, push B with out_ready=1 -> occupancy stays 1, head becomes B next cycle.
REQ-035 Flush vs push: FULL, assert flush with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_regwrite=0, in_ready=1; flushed input never appears.
REQ-036 Async reset: FULL, drop reset between edges -> out_valid=0, occupancy=0, in_ready=1 before next edge; push on first edge after release -> out_valid=1 next cycle.
REQ-037 Parameters: DATA_W=64, RA_W=5, PROD_W=128, push alu=0xFFFF_FFFF_FFFF_FFFF -> out_alu and out_wb_data equal it at full width.
